// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32 sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC_I,
    EXEC_B,
    WB,
    TRAP
  } state_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] FUNCT3_BNE = 3'b001;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-fetch handshake plus decode/ALU control bundle.
// master = sequencer side, slave = memory/datapath side.
interface multicycle_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] imm_ext;
  logic        alu_zero;
  logic        alu_src;
  logic        alu_sub;
  logic        rf_we;

  modport master (
    output imem_req, imem_addr, instr, opcode, alu_src, alu_sub, rf_we,
    input  imem_valid, imem_rdata, imm_ext, alu_zero
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, alu_src, alu_sub, rf_we,
    output imem_valid, imem_rdata, imm_ext, alu_zero
  );
endinterface

// File: rtl/multicycle_ctrl_fetch_timeout_ctr.sv
// 8-bit saturating wait counter for the fetch handshake.
// expired_o flags the cycle whose count would reach LIMIT.
module fetch_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Clear wins over enable; count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = 8'd0;
    else if (en_i && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = en_i & ~clr_i & (cnt_q >= LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for a minimal RV32 core (addi + bne).
// Optional macro PERF_CNT_EN adds cycle / retired-instruction counters;
// without it both counter ports read constant 0.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    bus,
  output logic [31:0]          pc,
  output logic                 halted,
  output logic [1:0]           fault_code,
  output logic [31:0]          cycle_cnt,
  output logic [31:0]          instret_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  fault_e      fault_q, fault_d;
  logic        fetch_expired;

  // Wait counter runs only while a fetch is pending without data.
  fetch_timeout_ctr #(.LIMIT(FETCH_TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     ((state_q != FETCH) | bus.imem_valid),
    .en_i      ((state_q == FETCH) & ~bus.imem_valid),
    .expired_o (fetch_expired)
  );

  // State, PC, IR and fault registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  // Next-state, PC update and trap decisions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    case (state_q)
      FETCH: begin
        if (bus.imem_valid) begin
          instr_d = bus.imem_rdata;
          state_d = DECODE;
        end else if (fetch_expired) begin
          state_d = TRAP;
          fault_d = FAULT_TIMEOUT;
        end
      end
      DECODE: begin
        if (instr_q[6:0] == OPC_OP_IMM)
          state_d = EXEC_I;
        else if (instr_q[6:0] == OPC_BRANCH && instr_q[14:12] == FUNCT3_BNE)
          state_d = EXEC_B;
        else begin
          state_d = TRAP;
          fault_d = FAULT_ILLEGAL;
        end
      end
      EXEC_I: state_d = WB;
      WB: begin
        pc_d    = pc_q + 32'd4;
        state_d = FETCH;
      end
      EXEC_B: begin
        // bne: a non-zero difference means the operands differ -> taken.
        pc_d    = bus.alu_zero ? pc_q + 32'd4 : pc_q + bus.imm_ext;
        state_d = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  assign bus.imem_req  = (state_q == FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.instr     = instr_q;
  assign bus.opcode    = instr_q[6:0];
  assign bus.alu_src   = (state_q == EXEC_I);
  assign bus.alu_sub   = (state_q == EXEC_B);
  assign bus.rf_we     = (state_q == WB);
  assign pc            = pc_q;
  assign halted        = (state_q == TRAP);
  assign fault_code    = fault_q;

`ifdef PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;
  logic        retire;

  assign retire = (state_q == WB) || (state_q == EXEC_B);

  // Free-running cycle count and retire count, both wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= 32'd0;
      ret_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      ret_q <= ret_q + {31'd0, retire};
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule
